// File: rtl/regfile_sweep.sv
// Parametrised multi-port register file with write handshake, HI/LO and a sequential bulk-clear sweep.
// Optional read/HI/LO write-through forwarding is enabled by defining REGFILE_BYPASS_EN.

module regfile_sweep_chk #(
   parameter int ADDR_W = 5
) (
   input logic              Clk,
   input logic              clr_n,
   input logic              busy,
   input logic              wr_ready,
   input logic [ADDR_W-1:0] idx
);
   localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};

   a_ready_busy: assert property (@(posedge Clk) disable iff (!clr_n) busy == !wr_ready);
   a_idx_nonzero: assert property (@(posedge Clk) disable iff (!clr_n) busy |-> (idx != {ADDR_W{1'b0}}));
   a_sweep_ends: assert property (@(posedge Clk) disable iff (!clr_n) (busy && (idx == IDX_LAST)) |=> !busy);
endmodule

module regfile_sweep #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 2
) (
   input  logic                  Clk,
   input  logic                  clr_n,
   input  logic [NRD*ADDR_W-1:0] ra,
   output logic [NRD*DATA_W-1:0] rd,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  hi_we,
   input  logic                  lo_we,
   input  logic [DATA_W-1:0]     hilo_data,
   output logic [DATA_W-1:0]     hi,
   output logic [DATA_W-1:0]     lo,
   input  logic                  clr_req,
   output logic                  busy
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SWEEP = 1'b1;
   localparam logic [ADDR_W-1:0] IDX_ZERO  = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] IDX_FIRST = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] IDX_LAST  = {ADDR_W{1'b1}};

   logic [0:0]        state_r;
   logic [ADDR_W-1:0] idx_r;
   logic              busy_r;
   logic              wr_ready_r;
   logic [DATA_W-1:0] regs_r [DEPTH];
   logic [DATA_W-1:0] hi_r;
   logic [DATA_W-1:0] lo_r;
   logic              wr_fire_s;
   logic              sweep_s;

   assign wr_fire_s = wr_valid & wr_ready_r;
   assign sweep_s   = (state_r == ST_SWEEP);
   assign busy      = busy_r;
   assign wr_ready  = wr_ready_r;

   // Sweep sequencer: IDLE <-> SWEEP, walking idx from 1 up to the last register without wrapping
   always_ff @(posedge Clk) begin
      if (!clr_n) begin
         state_r    <= ST_IDLE;
         idx_r      <= IDX_ZERO;
         busy_r     <= 1'b0;
         wr_ready_r <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (clr_req) begin
                  state_r    <= ST_SWEEP;
                  idx_r      <= IDX_FIRST;
                  busy_r     <= 1'b1;
                  wr_ready_r <= 1'b0;
               end else begin
                  state_r    <= ST_IDLE;
               end
            end
            ST_SWEEP: begin
               if (idx_r == IDX_LAST) begin
                  state_r    <= ST_IDLE;
                  idx_r      <= IDX_ZERO;
                  busy_r     <= 1'b0;
                  wr_ready_r <= 1'b1;
               end else begin
                  idx_r      <= idx_r + IDX_FIRST;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               idx_r      <= IDX_ZERO;
               busy_r     <= 1'b0;
               wr_ready_r <= 1'b1;
            end
         endcase
      end
   end

   // Register array: handshake writes in IDLE, one cleared entry per cycle in SWEEP
   always_ff @(posedge Clk) begin
      if (!clr_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else begin
         if (wr_fire_s && (wr_addr != IDX_ZERO)) begin
            regs_r[wr_addr] <= wr_data;
         end else if (sweep_s) begin
            regs_r[idx_r] <= {DATA_W{1'b0}};
         end
      end
   end

   // HI/LO holding registers, untouched by the sweep
   always_ff @(posedge Clk) begin
      if (!clr_n) begin
         hi_r <= {DATA_W{1'b0}};
         lo_r <= {DATA_W{1'b0}};
      end else begin
         if (hi_we) begin
            hi_r <= hilo_data;
         end
         if (lo_we) begin
            lo_r <= hilo_data;
         end
      end
   end

   // Combinational read ports; address 0 always reads zero
   always_comb begin
      rd = {(NRD*DATA_W){1'b0}};
      for (int k = 0; k < NRD; k++) begin
         if (ra[k*ADDR_W +: ADDR_W] == IDX_ZERO) begin
            rd[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
         end else if (wr_fire_s && (wr_addr == ra[k*ADDR_W +: ADDR_W])) begin
            rd[k*DATA_W +: DATA_W] = wr_data;
`endif
         end else begin
            rd[k*DATA_W +: DATA_W] = regs_r[ra[k*ADDR_W +: ADDR_W]];
         end
      end
   end

   // HI/LO output view
   always_comb begin
`ifdef REGFILE_BYPASS_EN
      if (hi_we) begin
         hi = hilo_data;
      end else begin
         hi = hi_r;
      end
      if (lo_we) begin
         lo = hilo_data;
      end else begin
         lo = lo_r;
      end
`else
      hi = hi_r;
      lo = lo_r;
`endif
   end

   regfile_sweep_chk #(.ADDR_W(ADDR_W)) u_chk (
      .Clk      (Clk),
      .clr_n    (clr_n),
      .busy     (busy_r),
      .wr_ready (wr_ready_r),
      .idx      (idx_r)
   );
endmodule
